cbcdes_arbiter: RTL and testbench

//  Shares one cbcdes core between NCH requester channels with message-granular round-robin arbitration.
//  A message is a first block (carries mode/key/iv, drives core start) followed by chained blocks.
//  The message ends on a block flagged last. Holds the grant for a whole message so CBC chaining is never interleaved.

---
 rtl/cbcdes_arbiter.sv | 137 +++++++++++++
 tb/tb_cbcdes_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbcdes_arbiter.sv
// Message-granular round-robin arbiter sharing one cbcdes core between NCH channels.
// The grant is held from a first block until the result of the block flagged last (or a timeout).
module cbcdes_arbiter #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NCH-1:0]    ch_valid_i,
    input  logic [NCH-1:0]    ch_first_i,
    input  logic [NCH-1:0]    ch_last_i,
    input  logic [NCH-1:0]    ch_mode_i,
    input  logic [64*NCH-1:0] ch_key_i,
    input  logic [64*NCH-1:0] ch_iv_i,
    input  logic [64*NCH-1:0] ch_data_i,
    output logic [NCH-1:0]    ch_ready_o,
    output logic [63:0]       ch_data_o,
    output logic [NCH-1:0]    ch_valid_o,
    output logic [NCH-1:0]    ch_abort_o,
    output logic              core_start_o,
    output logic              core_mode_o,
    output logic [63:0]       core_key_o,
    output logic [63:0]       core_iv_o,
    output logic [63:0]       core_data_o,
    output logic              core_valid_o,
    input  logic              core_ready_i,
    input  logic [63:0]       core_data_i,
    input  logic              core_valid_i
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_grant;
    logic [CW-1:0]  r_rr;
    logic           r_inflight;
    logic           r_last;
    logic [TW-1:0]  r_timer;

    logic           w_busy;
    logic           w_found;
    logic [CW-1:0]  w_pick;
    int unsigned    w_idx;
    logic           w_accept;
    logic           w_result;
    logic           w_tmo;
    logic [CW-1:0]  w_rr_next;

    assign w_busy = (r_state == StBusy);

    // Cyclic search for the first start request at or after the rr pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_idx = 32'(r_rr) + i;
            if (w_idx >= NCH) begin
                w_idx = w_idx - NCH;
            end
            if (!w_found && ch_valid_i[CW'(w_idx)] && ch_first_i[CW'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = CW'(w_idx);
            end
        end
    end

    always_comb begin
        core_valid_o = w_busy & ch_valid_i[r_grant] & ~r_inflight;
        core_start_o = w_busy & ch_first_i[r_grant];
        core_mode_o  = w_busy & ch_mode_i[r_grant];
        core_key_o   = w_busy ? ch_key_i[64*r_grant +: 64]  : '0;
        core_iv_o    = w_busy ? ch_iv_i[64*r_grant +: 64]   : '0;
        core_data_o  = w_busy ? ch_data_i[64*r_grant +: 64] : '0;

        w_accept = core_valid_o & core_ready_i;
        w_result = w_busy & r_inflight & core_valid_i;
        w_tmo    = (TIMEOUT != 0) && w_busy && !r_inflight && !w_accept && (r_timer == TMAX);

        ch_ready_o = '0;
        ch_valid_o = '0;
        ch_abort_o = '0;
        ch_ready_o[r_grant] = w_busy & core_ready_i & ~r_inflight;
        ch_valid_o[r_grant] = w_result;
        ch_abort_o[r_grant] = w_tmo;
        ch_data_o = w_result ? core_data_i : '0;

        w_rr_next = (r_grant == CW'(NCH - 1)) ? '0 : r_grant + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= StIdle;
            r_grant    <= '0;
            r_rr       <= '0;
            r_inflight <= 1'b0;
            r_last     <= 1'b0;
            r_timer    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_inflight <= 1'b0;
                    r_timer    <= '0;
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    if (w_accept) begin
                        r_inflight <= 1'b1;
                        r_last     <= ch_last_i[r_grant];
                        r_timer    <= '0;
                    end else if (w_result) begin
                        r_inflight <= 1'b0;
                        if (r_last) begin
                            r_state <= StIdle;
                            r_rr    <= w_rr_next;
                        end
                    end else if (w_tmo) begin
                        r_state <= StIdle;
                        r_rr    <= w_rr_next;
                        r_timer <= '0;
                    end else if (!r_inflight && (TIMEOUT != 0)) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cbcdes_arbiter.sv
// Self-checking bench for cbcdes_arbiter with a small chained toy block-cipher core model.
module tb_cbcdes_arbiter;

    localparam int NCH = 2;
    localparam int TMO = 16;
    localparam int LAT = 3;

    localparam logic [63:0] K0  = 64'h0123456789ABCDEF;
    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] IV0 = 64'h0;
    localparam logic [63:0] IV1 = 64'hA5A55A5A0F0FF0F0;
    localparam logic [63:0] P0  = 64'h4E6F772069732074;
    localparam logic [63:0] P1  = 64'h68652074696D6520;
    localparam logic [63:0] P2  = 64'h666F7220616C6C20;

    logic               clk;
    logic               rst_n;
    logic [NCH-1:0]     ch_valid_i, ch_first_i, ch_last_i, ch_mode_i;
    logic [64*NCH-1:0]  ch_key_i, ch_iv_i, ch_data_i;
    logic [NCH-1:0]     ch_ready_o, ch_valid_o, ch_abort_o;
    logic [63:0]        ch_data_o;
    logic               core_start_o, core_mode_o, core_valid_o;
    logic [63:0]        core_key_o, core_iv_o, core_data_o;
    logic               core_ready_i, core_valid_i;
    logic [63:0]        core_data_i;

    cbcdes_arbiter #(
        .NCH     (NCH),
        .TIMEOUT (TMO)
    ) u_dut (
        .clk_i        (clk),
        .reset_i      (rst_n),
        .ch_valid_i   (ch_valid_i),
        .ch_first_i   (ch_first_i),
        .ch_last_i    (ch_last_i),
        .ch_mode_i    (ch_mode_i),
        .ch_key_i     (ch_key_i),
        .ch_iv_i      (ch_iv_i),
        .ch_data_i    (ch_data_i),
        .ch_ready_o   (ch_ready_o),
        .ch_data_o    (ch_data_o),
        .ch_valid_o   (ch_valid_o),
        .ch_abort_o   (ch_abort_o),
        .core_start_o (core_start_o),
        .core_mode_o  (core_mode_o),
        .core_key_o   (core_key_o),
        .core_iv_o    (core_iv_o),
        .core_data_o  (core_data_o),
        .core_valid_o (core_valid_o),
        .core_ready_i (core_ready_i),
        .core_data_i  (core_data_i),
        .core_valid_i (core_valid_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toy chained cipher: enc out = rotl8(d ^ prev) ^ k, dec is its exact inverse.
    function automatic logic [63:0] ref_out(input logic mode, input logic [63:0] k,
                                            input logic [63:0] p, input logic [63:0] d);
        logic [63:0] x;
        if (!mode) begin
            x = d ^ p;
            return {x[55:0], x[63:56]} ^ k;
        end
        x = d ^ k;
        return {x[7:0], x[63:8]} ^ p;
    endfunction

    function automatic logic [63:0] ref_next(input logic mode, input logic [63:0] k,
                                             input logic [63:0] p, input logic [63:0] d);
        return mode ? d : ref_out(1'b0, k, p, d);
    endfunction

    // Core model: fixed latency, one block at a time, chain state reloaded from iv on start.
    logic        cbusy, cval;
    logic [63:0] cres, cst;
    int          ccnt;
    assign core_ready_i = ~cbusy;
    assign core_valid_i = cval;
    assign core_data_i  = cres;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cbusy <= 1'b0;
            cval  <= 1'b0;
            ccnt  <= 0;
            cres  <= '0;
            cst   <= '0;
        end else begin
            cval <= 1'b0;
            if (core_valid_o && core_ready_i) begin
                cres  <= ref_out(core_mode_o, core_key_o, core_start_o ? core_iv_o : cst,
                                 core_data_o);
                cst   <= ref_next(core_mode_o, core_key_o, core_start_o ? core_iv_o : cst,
                                  core_data_o);
                cbusy <= 1'b1;
                ccnt  <= LAT - 1;
            end else if (cbusy) begin
                if (ccnt == 0) begin
                    cval  <= 1'b1;
                    cbusy <= 1'b0;
                end else begin
                    ccnt <= ccnt - 1;
                end
            end
        end
    end

    typedef struct packed {
        logic        first;
        logic        last;
        logic        mode;
        logic [63:0] key;
        logic [63:0] iv;
        logic [63:0] data;
    } blk_t;

    typedef struct {
        int          ch;
        logic        mode;
        int          n;
        logic [63:0] key;
        logic [63:0] iv;
        logic [63:0] din  [3];
        logic [63:0] dexp [3];
    } vec_t;

    blk_t        q0[$], q1[$];
    int          res_ch[$];
    logic [63:0] res_data[$];
    logic [NCH-1:0] s_ready;
    int n_checks = 0, n_pass = 0;
    int cyc = 0, last_res_cyc = 0, ab_cyc = 0, ab_cnt = 0;
    logic [NCH-1:0] ab_mask = '0;
    int onehot_viol = 0, multi_viol = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic put(input int c, input blk_t b);
        ch_valid_i[c]          = 1'b1;
        ch_first_i[c]          = b.first;
        ch_last_i[c]           = b.last;
        ch_mode_i[c]           = b.mode;
        ch_key_i[64*c +: 64]   = b.key;
        ch_iv_i[64*c +: 64]    = b.iv;
        ch_data_i[64*c +: 64]  = b.data;
    endtask

    task automatic clear_inputs();
        ch_valid_i = '0; ch_first_i = '0; ch_last_i = '0; ch_mode_i = '0;
        ch_key_i   = '0; ch_iv_i    = '0; ch_data_i = '0;
    endtask

    // One clock: present queue heads at negedge, sample outputs, pop accepted blocks.
    task automatic step();
        logic [NCH-1:0] acc;
        @(negedge clk);
        clear_inputs();
        if (q0.size() > 0) put(0, q0[0]);
        if (q1.size() > 0) put(1, q1[0]);
        #1;
        s_ready = ch_ready_o;
        acc = ch_valid_i & ch_ready_o;
        if ($countones(ch_ready_o) > 1) multi_viol++;
        if (|ch_valid_o) begin
            if ($countones(ch_valid_o) != 1) onehot_viol++;
            res_ch.push_back(ch_valid_o[1] ? 1 : 0);
            res_data.push_back(ch_data_o);
            last_res_cyc = cyc;
        end
        if (|ch_abort_o) begin
            ab_mask |= ch_abort_o;
            ab_cnt++;
            ab_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
    endtask

    task automatic push_blk(input int c, input logic first, input logic last, input logic mode,
                            input logic [63:0] k, input logic [63:0] iv, input logic [63:0] d);
        blk_t b;
        b.first = first; b.last = last; b.mode = mode; b.key = k; b.iv = iv; b.data = d;
        if (c == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic push_msg(input int c, input logic mode, input logic [63:0] k,
                            input logic [63:0] iv, input logic [63:0] d [3], input int n);
        for (int i = 0; i < n; i++) push_blk(c, i == 0, i == n - 1, mode, k, iv, d[i]);
    endtask

    task automatic run_until(input int nres, input int budget, input string name);
        int k = 0;
        while (res_data.size() < nres && k < budget) begin
            step();
            k++;
        end
        chk({name, " result count"}, 64'(res_data.size()), 64'(nres));
    endtask

    task automatic clear_res();
        res_ch.delete();
        res_data.delete();
    endtask

    vec_t tv [4];
    logic [63:0] da [3];
    logic [63:0] e1a, e1b, pv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Vector table: encrypt entries get expectations from the reference cipher,
        // decrypt entries must return the known plaintext.
        tv[0].ch = 0; tv[0].mode = 1'b0; tv[0].n = 3; tv[0].key = K0; tv[0].iv = IV0;
        tv[0].din = '{P0, P1, P2};
        tv[1].ch = 1; tv[1].mode = 1'b0; tv[1].n = 2; tv[1].key = K1; tv[1].iv = IV1;
        tv[1].din = '{64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0};
        for (int v = 0; v < 2; v++) begin
            pv = tv[v].iv;
            for (int i = 0; i < 3; i++) begin
                tv[v].dexp[i] = ref_out(1'b0, tv[v].key, pv, tv[v].din[i]);
                pv = ref_next(1'b0, tv[v].key, pv, tv[v].din[i]);
            end
        end
        tv[2].ch = 0; tv[2].mode = 1'b1; tv[2].n = 3; tv[2].key = K0; tv[2].iv = IV0;
        tv[2].din = tv[0].dexp; tv[2].dexp = '{P0, P1, P2};
        tv[3].ch = 1; tv[3].mode = 1'b1; tv[3].n = 1; tv[3].key = K1; tv[3].iv = IV1;
        tv[3].din = '{tv[1].dexp[0], 64'h0, 64'h0}; tv[3].dexp = '{64'h0, 64'h0, 64'h0};

        // Reset state with requests already asserted.
        rst_n = 1'b0;
        clear_inputs();
        ch_valid_i = 2'b11;
        ch_first_i = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ch_ready_o", 64'(ch_ready_o), 64'h0);
        chk("reset ch_valid_o", 64'(ch_valid_o), 64'h0);
        chk("reset ch_abort_o", 64'(ch_abort_o), 64'h0);
        chk("reset core_valid_o", 64'(core_valid_o), 64'h0);
        chk("reset core_start_o", 64'(core_start_o), 64'h0);
        chk("reset ch_data_o", ch_data_o, 64'h0);
        clear_inputs();
        rst_n = 1'b1;
        step();

        // Table-driven single-channel messages.
        for (int v = 0; v < 4; v++) begin
            clear_res();
            push_msg(tv[v].ch, tv[v].mode, tv[v].key, tv[v].iv, tv[v].din, tv[v].n);
            run_until(tv[v].n, 100, $sformatf("vec%0d", v));
            for (int j = 0; j < tv[v].n && j < res_data.size(); j++) begin
                chk($sformatf("vec%0d ch%0d", v, j), 64'(res_ch[j]), 64'(tv[v].ch));
                chk($sformatf("vec%0d data%0d", v, j), res_data[j], tv[v].dexp[j]);
            end
            step();
            step();
        end

        // Contention with rr=0: ch0 message completes before ch1 sees ready.
        begin
            int k = 0, n0 = 0, iso = 0;
            clear_res();
            da = '{P0, P1, 64'h0};
            push_msg(0, 1'b0, K0, IV0, da, 2);
            da = '{P2, P0, 64'h0};
            push_msg(1, 1'b0, K1, IV1, da, 2);
            e1a = ref_out(1'b0, K1, IV1, P2);
            e1b = ref_out(1'b0, K1, e1a, P0);
            step();
            chk("arb cycle ready", 64'(s_ready), 64'h0);
            step();
            chk("grant ready", 64'(s_ready), 64'h1);
            while (res_data.size() < 4 && k < 200) begin
                n0 = 0;
                foreach (res_ch[i]) if (res_ch[i] == 0) n0++;
                step();
                if (s_ready[1] && n0 < 2) iso++;
                k++;
            end
            chk("contention count", 64'(res_data.size()), 64'd4);
            chk("isolation ch1 ready", 64'(iso), 64'h0);
            if (res_data.size() == 4) begin
                chk("contention order", {res_ch[0][1:0], res_ch[1][1:0], res_ch[2][1:0],
                    res_ch[3][1:0]}, 64'b00_00_01_01);
                chk("contention d0", res_data[0], tv[0].dexp[0]);
                chk("contention d1", res_data[1], tv[0].dexp[1]);
                chk("contention d2", res_data[2], e1a);
                chk("contention d3", res_data[3], e1b);
            end
            step();
            step();
        end

        // ch0 alone moves rr to 1, so the next contention favours ch1.
        clear_res();
        push_blk(0, 1'b1, 1'b1, 1'b0, K0, IV0, P0);
        run_until(1, 50, "solo ch0");
        step();
        step();
        clear_res();
        push_blk(0, 1'b1, 1'b1, 1'b0, K0, IV0, P0);
        push_blk(1, 1'b1, 1'b1, 1'b0, K1, IV1, P2);
        run_until(2, 100, "contention2");
        if (res_data.size() == 2) begin
            chk("contention2 order", {res_ch[0][1:0], res_ch[1][1:0]}, 64'b01_00);
            chk("contention2 d0", res_data[0], e1a);
            chk("contention2 d1", res_data[1], tv[0].dexp[0]);
        end
        step();
        step();

        // Timeout: ch0 first block without last, then stalls.
        begin
            int k = 0, rc;
            clear_res();
            push_blk(0, 1'b1, 1'b0, 1'b0, K0, IV0, P1);
            run_until(1, 50, "timeout first block");
            rc = last_res_cyc;
            push_blk(1, 1'b1, 1'b1, 1'b0, K1, IV1, P2);
            while (ab_cnt == 0 && k < 60) begin
                step();
                k++;
            end
            chk("abort seen", 64'(ab_cnt), 64'd1);
            chk("abort delay", 64'(ab_cyc - rc), 64'(TMO));
            chk("abort channel", 64'(ab_mask), 64'h1);
            run_until(2, 50, "after abort ch1");
            if (res_data.size() == 2) begin
                chk("after abort ch", 64'(res_ch[1]), 64'd1);
                chk("after abort data", res_data[1], e1a);
            end
            step();
            step();
            clear_res();
            push_blk(0, 1'b1, 1'b1, 1'b0, K0, IV0, P0);
            run_until(1, 50, "restart ch0");
            if (res_data.size() == 1) chk("restart ch0 data", res_data[0], tv[0].dexp[0]);
            chk("abort total", 64'(ab_cnt), 64'd1);
            step();
            step();
        end

        // Non-first block from IDLE must never be granted.
        begin
            int rdy = 0;
            clear_res();
            push_blk(1, 1'b0, 1'b1, 1'b0, K1, IV1, P0);
            for (int i = 0; i < 20; i++) begin
                step();
                if (s_ready[1]) rdy++;
            end
            chk("nonfirst ready cycles", 64'(rdy), 64'h0);
            chk("nonfirst results", 64'(res_data.size()), 64'h0);
            q1.delete();
            step();
        end

        // Reset with a block in flight, then decrypt from iv.
        begin
            int k = 0;
            clear_res();
            da = '{P0, P1, 64'h0};
            push_msg(0, 1'b0, K0, IV0, da, 2);
            while (q0.size() == 2 && k < 20) begin
                step();
                k++;
            end
            step();
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("midreset ch_ready_o", 64'(ch_ready_o), 64'h0);
            chk("midreset ch_valid_o", 64'(ch_valid_o), 64'h0);
            chk("midreset ch_abort_o", 64'(ch_abort_o), 64'h0);
            chk("midreset core_valid_o", 64'(core_valid_o), 64'h0);
            chk("midreset core_start_o", 64'(core_start_o), 64'h0);
            chk("midreset core_data_o", core_data_o, 64'h0);
            q0.delete();
            clear_inputs();
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            clear_res();
            push_msg(0, 1'b1, K0, IV0, tv[0].dexp, 3);
            run_until(3, 100, "post reset decrypt");
            for (int j = 0; j < 3 && j < res_data.size(); j++) begin
                chk($sformatf("post reset ch%0d", j), 64'(res_ch[j]), 64'h0);
                chk($sformatf("post reset data%0d", j), res_data[j], tv[2].dexp[j]);
            end
        end

        chk("ch_valid_o one-hot", 64'(onehot_viol), 64'h0);
        chk("ch_ready_o at most one", 64'(multi_viol), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
